pipelined_hybrid_adder: RTL and testbench

//  Parametrised, pipelined successor of the 32-bit block-CLA adder used by the ALU.
//  - WIDTH-bit add/subtract: BLOCK-bit carry-lookahead blocks, rippled within a stage.
//  - Blocks are split across STAGES register stages, with a valid/ready elastic handshake.
//  - Produces sum, carry, signed overflow and zero flags for the execute stage.
//  - Full throughput: one operation accepted per cycle when not stalled.

---
 rtl/pipelined_hybrid_adder_pkg.sv | 14 +
 rtl/pipelined_hybrid_adder_cla_block.sv | 39 +++
 rtl/pipelined_hybrid_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_hybrid_adder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_hybrid_adder_pkg.sv
// Shared definitions for the pipelined hybrid adder: operation encodings
// and the elaboration-time check on the WIDTH/BLOCK/STAGES relationship.
package pipelined_hybrid_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Stages must split the word into whole lookahead blocks.
  function automatic bit cfgOk(input int width, input int block, input int stages);
    return (block >= 1) && (stages >= 1) && (stages <= width / block) &&
           (width % (block * stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_hybrid_adder_cla_block.sv
// Generic BLOCK-bit carry-lookahead adder: every internal carry is a flat
// sum-of-products of generate/propagate terms rather than a ripple chain.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;
  logic             w_run;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    w_g    = i_a & i_b;
    w_p    = i_a ^ i_b;
    w_c    = '0;
    w_c[0] = i_cin;
    w_run  = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      w_run      = w_p[i];
      w_c[i + 1] = w_g[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i + 1] = w_c[i + 1] | (w_run & w_g[j]);
        w_run      = w_run & w_p[j];
      end
      w_c[i + 1] = w_c[i + 1] | (w_run & i_cin);
    end
  end

  assign o_sum  = w_p ^ w_c[BLOCK-1:0];
  assign o_cout = w_c[BLOCK];

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// Pipelined add/subtract built from lookahead blocks rippled within each stage,
// with an elastic valid/ready chain so a full pipe stalls without losing data.
module pipelined_hybrid_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  import pipelined_hybrid_adder_pkg::*;

  localparam int SW   = WIDTH / STAGES;
  localparam int BPS  = SW / BLOCK;
  localparam int NREG = STAGES + 1;
  localparam int MSB  = WIDTH - 1;

  if (!cfgOk(WIDTH, BLOCK, STAGES)) begin : g_badCfg
    $error("pipelined_hybrid_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  // Register 0 captures the mapped operands; register k holds results after slice k-1.
  logic             r_valid [NREG];
  logic [WIDTH-1:0] r_a     [NREG];
  logic [WIDTH-1:0] r_b     [NREG];
  logic [WIDTH-1:0] r_sum   [NREG];
  logic             r_cy    [NREG];
  logic             r_ovf;
  logic             r_zero;
  logic [NREG:0]    w_adv;
  logic [WIDTH-1:0] w_bEff;
  logic             w_cinEff;

  assign w_bEff   = (sub == OP_SUB) ? ~b : b;
  assign w_cinEff = (sub == OP_SUB) ? ~c_in : c_in;

  always_comb begin
    w_adv       = '0;
    w_adv[NREG] = out_ready;
    for (int k = NREG - 1; k >= 0; k--) begin
      w_adv[k] = ~r_valid[k] | w_adv[k + 1];
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_stage
    logic             w_inV;
    logic [WIDTH-1:0] w_inA;
    logic [WIDTH-1:0] w_inB;
    logic [WIDTH-1:0] w_nxtSum;
    logic             w_nxtCy;

    if (k == 0) begin : g_in
      assign w_inV    = in_valid;
      assign w_inA    = a;
      assign w_inB    = w_bEff;
      assign w_nxtSum = '0;
      assign w_nxtCy  = w_cinEff;
    end else begin : g_add
      logic          w_bc [BPS + 1];
      logic [SW-1:0] w_slice;

      assign w_bc[0] = r_cy[k - 1];
      for (genvar j = 0; j < BPS; j++) begin : g_blk
        cla_block #(.BLOCK(BLOCK)) u_cla (
          .i_a   (r_a[k - 1][(k - 1) * SW + j * BLOCK +: BLOCK]),
          .i_b   (r_b[k - 1][(k - 1) * SW + j * BLOCK +: BLOCK]),
          .i_cin (w_bc[j]),
          .o_sum (w_slice[j * BLOCK +: BLOCK]),
          .o_cout(w_bc[j + 1])
        );
      end

      assign w_inV   = r_valid[k - 1];
      assign w_inA   = r_a[k - 1];
      assign w_inB   = r_b[k - 1];
      assign w_nxtCy = w_bc[BPS];

      always_comb begin
        w_nxtSum                     = r_sum[k - 1];
        w_nxtSum[(k - 1) * SW +: SW] = w_slice;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_cy[k]    <= 1'b0;
      end else if (w_adv[k]) begin
        r_valid[k] <= w_inV;
        if (w_inV) begin
          r_a[k]   <= w_inA;
          r_b[k]   <= w_inB;
          r_sum[k] <= w_nxtSum;
          r_cy[k]  <= w_nxtCy;
        end
      end
    end

    // Flags follow the final sum into the output register.
    if (k == NREG - 1) begin : g_flags
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv[k] && w_inV) begin
          r_ovf  <= (w_inA[MSB] == w_inB[MSB]) && (w_nxtSum[MSB] != w_inA[MSB]);
          r_zero <= ~|w_nxtSum;
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[NREG - 1];
  assign sum       = r_sum[NREG - 1];
  assign c_out     = r_cy[NREG - 1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Directed and randomised bench for pipelined_hybrid_adder (default parameters)
// using a result queue filled on accepted inputs and drained on emitted outputs.
module tb_pipelined_hybrid_adder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             ovf;
    logic             zero;
  } result_t;

  result_t expQ[$];
  result_t lastOut;
  int      compareCount = 0;
  int      failCount    = 0;
  int      outCount     = 0;
  logic    gotOut;
  logic    accepted;
  logic    sawStall;

  always #5 clk = ~clk;

  pipelined_hybrid_adder #(.WIDTH(WIDTH), .BLOCK(4), .STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  function automatic result_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                    input logic vc, input logic vs);
    result_t          m;
    logic [WIDTH-1:0] bEff;
    logic             cinEff;
    logic [WIDTH:0]   r;
    bEff   = vs ? ~vb : vb;
    cinEff = vs ? ~vc : vc;
    r      = {1'b0, va} + {1'b0, bEff} + {{WIDTH{1'b0}}, cinEff};
    m.sum  = r[WIDTH-1:0];
    m.cOut = r[WIDTH];
    m.ovf  = (va[WIDTH-1] == bEff[WIDTH-1]) && (r[WIDTH-1] != va[WIDTH-1]);
    m.zero = (r[WIDTH-1:0] == '0);
    return m;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vc, input logic vs, input logic vv, input logic vr);
    a         = va;
    b         = vb;
    c_in      = vc;
    sub       = vs;
    in_valid  = vv;
    out_ready = vr;
  endtask

  // Samples the handshake on the falling edge, then advances past the next rising edge.
  task automatic checkOutput();
    result_t e;
    @(negedge clk);
    gotOut   = 1'b0;
    accepted = 1'b0;
    if (rst_n) begin
      if (in_valid && !in_ready) sawStall = 1'b1;
      if (out_valid && out_ready) begin
        outCount++;
        checkVal("queue_nonempty_on_output", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkVal("sum", 64'(sum), 64'(e.sum));
          checkVal("c_out", 64'(c_out), 64'(e.cOut));
          checkVal("overflow", 64'(overflow), 64'(e.ovf));
          checkVal("zero", 64'(zero), 64'(e.zero));
          lastOut = '{sum: sum, cOut: c_out, ovf: overflow, zero: zero};
          gotOut  = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(a, b, c_in, sub));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutput(input string tag, input int maxCycles);
    gotOut = 1'b0;
    for (int i = 0; i < maxCycles && !gotOut; i++) checkOutput();
    checkVal({tag, "_timeout"}, 64'(gotOut), 64'd1);
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, input logic vs, input logic [WIDTH-1:0] expSum,
                          input logic expC, input logic expOvf, input logic expZero);
    applyStimulus(va, vb, vc, vs, 1'b1, 1'b1);
    checkOutput();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitOutput(tag, 10);
    if (gotOut) begin
      checkVal({tag, "_sum"}, 64'(lastOut.sum), 64'(expSum));
      checkVal({tag, "_c_out"}, 64'(lastOut.cOut), 64'(expC));
      checkVal({tag, "_overflow"}, 64'(lastOut.ovf), 64'(expOvf));
      checkVal({tag, "_zero"}, 64'(lastOut.zero), 64'(expZero));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs, rv, pending;
    int               cyc, guard, startCount;

    sawStall = 1'b0;
    gotOut   = 1'b0;
    accepted = 1'b0;
    rst_n    = 1'b0;
    applyStimulus(32'hDEADBEEF, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput();
    checkOutput();
    checkVal("reset_out_valid", 64'(out_valid), 64'd0);
    checkVal("reset_sum", 64'(sum), 64'd0);
    checkVal("reset_c_out", 64'(c_out), 64'd0);
    checkVal("reset_overflow", 64'(overflow), 64'd0);
    checkVal("reset_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    checkVal("in_ready_after_reset", 64'(in_ready), 64'd1);
    checkVal("out_valid_after_reset", 64'(out_valid), 64'd0);

    $display("[TB] latency and add wrap");
    applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("latency_edge1", 64'(out_valid), 64'd0);
    checkOutput();
    checkVal("latency_edge2", 64'(out_valid), 64'd0);
    checkOutput();
    checkVal("latency_edge3", 64'(out_valid), 64'd1);
    waitOutput("add_wrap", 4);
    if (gotOut) begin
      checkVal("add_wrap_sum", 64'(lastOut.sum), 64'd0);
      checkVal("add_wrap_c_out", 64'(lastOut.cOut), 64'd1);
      checkVal("add_wrap_zero", 64'(lastOut.zero), 64'd1);
      checkVal("add_wrap_overflow", 64'(lastOut.ovf), 64'd0);
    end

    $display("[TB] directed subtract and boundary cases");
    directed("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    directed("max_cin", 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow_in", 32'd5, 32'd3, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    directed("add_pos_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    directed("add_carry_chain", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-pressure stream");
    startCount = outCount;
    sawStall   = 1'b0;
    cyc        = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'b1, 1'b1);
      guard = 0;
      do begin
        out_ready = !(cyc >= 3 && cyc <= 5);
        checkOutput();
        cyc++;
        guard++;
      end while (!accepted && guard < 50);
      checkVal("bp_accept_timeout", 64'(accepted), 64'd1);
    end
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) checkOutput();
    checkVal("bp_in_ready_dropped", 64'(sawStall), 64'd1);
    checkVal("bp_drain_empty", 64'(expQ.size()), 64'd0);
    checkVal("bp_emit_count", 64'(outCount - startCount), 64'd8);

    $display("[TB] random stream");
    pending = 1'b0;
    ra = '0; rb = '0; rc = 1'b0; rs = 1'b0; rv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
        if ($urandom_range(0, 7) == 0) rb = 32'h80000000;
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        rv = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(ra, rb, rc, rs, rv, ($urandom_range(0, 3) != 0));
      checkOutput();
      pending = rv && !accepted;
    end
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) checkOutput();
    checkVal("random_drain_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] mid-stream reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h100 + 32'(i), 32'h5, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput();
    end
    checkVal("mid_reset_inflight", 64'(expQ.size()), 64'd3);
    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    expQ.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput();
      checkVal("post_reset_no_out_valid", 64'(out_valid), 64'd0);
    end
    directed("post_reset_op", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789,
             1'b0, 1'b0, 1'b0);
    checkVal("final_queue_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
